mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency memory between the core's instruction-fetch requester (I, read-only) and its load/store requester (D, read/write).
- Sits between the multi-cycle core (IF/MEM stages) and the unified memory.
- One transaction in flight at a time; two-way round-robin on contention.
- Per-requester req/gnt/rvalid handshake, so the core's state machine stalls on memory instead of assuming single-cycle access.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_arb2.sv | 52 +++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - DEFAULT_WORD_LEN : default data and address width
//   - CNT_W            : width of the read latency counter (covers 1..15)
//   - arb_state_t      : arbiter FSM states (2 bits)
//   - owner_t          : which requester owns the memory (I = fetch, D = load/store)
package mem_arbiter_pkg;

    localparam int DEFAULT_WORD_LEN = 32;
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter, purely combinational. The history bit
// (last_owner) is stored by the parent so this block stays stateless.
// Ports:
//   req[1:0]   : request vector, bit 0 = I, bit 1 = D
//   last_owner : requester that won the previous arbitration
//   enable     : arbitration allowed this cycle (parent is idle)
//   gnt[1:0]   : one-hot grant, all zero when disabled or no request
//   winner     : the granted requester (only meaningful when |gnt)
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    input  logic       enable,
    output logic [1:0] gnt,
    output owner_t     winner
);

    // On a tie the requester that did not win last time gets the memory,
    // which yields strict alternation while both keep requesting.
    always_comb begin
        gnt    = 2'b00;
        winner = OWN_I;
        if (enable) begin
            case (req)
                2'b01: begin
                    winner = OWN_I;
                    gnt    = 2'b01;
                end
                2'b10: begin
                    winner = OWN_D;
                    gnt    = 2'b10;
                end
                2'b11: begin
                    if (last_owner == OWN_D) begin
                        winner = OWN_I;
                        gnt    = 2'b01;
                    end else begin
                        winner = OWN_D;
                        gnt    = 2'b10;
                    end
                end
                default: begin
                    winner = OWN_I;
                    gnt    = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, fixed-latency memory between the instruction
// fetch requester (I, read-only) and the load/store requester (D).
// One transaction is in flight at a time; ties are resolved round-robin.
// Parameters:
//   WORD_LEN   : data and address width
//   RD_LATENCY : cycles from the m_en cycle to valid m_rdata (1..15)
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   i_req/i_addr                     : fetch request, held until i_gnt
//   i_gnt/i_rvalid/i_rdata           : fetch grant pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata        : data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata           : data grant pulse, response pulse, load data
//   m_en/m_we/m_addr/m_wdata/m_rdata : memory interface
//   busy                             : high whenever a transaction is in progress
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_LEN   = DEFAULT_WORD_LEN,
    parameter int RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic                m_en,
    output logic                m_we,
    output logic [WORD_LEN-1:0] m_addr,
    output logic [WORD_LEN-1:0] m_wdata,
    input  logic [WORD_LEN-1:0] m_rdata,
    output logic                busy
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    owner_t           owner_q;
    owner_t           last_owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       arb_gnt;
    owner_t           arb_winner;
    logic             grant_now;

    // Arbitration is only enabled while idle, so requests raised during a
    // transaction simply wait with gnt low.
    rr_arb2 u_rr_arb2 (
        .req        ({d_req, i_req}),
        .last_owner (last_owner_q),
        .enable     (state_q == ARB_IDLE),
        .gnt        (arb_gnt),
        .winner     (arb_winner)
    );

    assign i_gnt     = arb_gnt[0];
    assign d_gnt     = arb_gnt[1];
    assign grant_now = |arb_gnt;

    // State register; reset lands in IDLE with D as last owner so that I
    // wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
        end else begin
            state_q <= state_d;
            if (grant_now) begin
                owner_q      <= arb_winner;
                last_owner_q <= arb_winner;
            end
        end
    end

    // Next-state and per-state outputs. m_en and the rvalid pulses are
    // decoded from the state register so a reset removes them immediately.
    always_comb begin
        state_d  = state_q;
        m_en     = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        busy     = 1'b1;
        case (state_q)
            ARB_IDLE: begin
                busy = 1'b0;
                if (grant_now) begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                m_en    = 1'b1;
                state_d = m_we ? ARB_RESP : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                i_rvalid = (owner_q == OWN_I);
                d_rvalid = (owner_q == OWN_D);
                state_d  = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Memory request registers are loaded at grant and then held; only m_en
    // qualifies them. A fetch never writes, and leaves m_wdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (grant_now) begin
            if (arb_winner == OWN_D) begin
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else begin
                m_we   <= 1'b0;
                m_addr <= i_addr;
            end
        end
    end

    // Read latency counter: loaded with RD_LATENCY-1 during ISSUE so that
    // WAIT spans exactly RD_LATENCY cycles and ends on the m_rdata cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ARB_ISSUE) begin
            cnt_q <= CNT_W'(RD_LATENCY - 1);
        end else if (state_q == ARB_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Read data capture into the owner's register on the last WAIT cycle;
    // the other side's register keeps its previous response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (state_q == ARB_WAIT && cnt_q == '0) begin
            if (owner_q == OWN_I) begin
                i_rdata <= m_rdata;
            end else begin
                d_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. The main instance (RD_LATENCY=2)
// is checked every cycle against a transaction-level timing model; a
// second instance (RD_LATENCY=1) gets a short directed read.
module tb_mem_arbiter;

    localparam int RD = 2;

    logic        clk;
    logic        rst_n;

    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    logic        i_req_b, d_req_b, d_we_b;
    logic [31:0] i_addr_b, d_addr_b, d_wdata_b;
    logic        i_gnt_b, i_rvalid_b, d_gnt_b, d_rvalid_b, m_en_b, m_we_b, busy_b;
    logic [31:0] i_rdata_b, d_rdata_b, m_addr_b, m_wdata_b, m_rdata_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          cyc;
    int          gnt_cyc, resp_cyc, free_at;
    logic        cur_d, cur_we, last_d, seen_ig, seen_dg;
    logic [31:0] cur_addr, cur_wdata, resp_word, exp_i_rdata, exp_d_rdata;
    logic [31:0] exp_mem [128];

    // memory device state
    logic [31:0] dev_mem [128];
    logic [31:0] rd_pipe [RD];
    logic        mem_loaded = 1'b0;

    mem_arbiter #(.WORD_LEN(32), .RD_LATENCY(RD)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy)
    );

    mem_arbiter #(.WORD_LEN(32), .RD_LATENCY(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req_b), .i_addr(i_addr_b), .i_gnt(i_gnt_b), .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_rdata(m_rdata_b),
        .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'({a[13], a[8], a[6:2]});
    endfunction

    function automatic logic [31:0] initWord(input int idx);
        if (idx == 32) return 32'h0050_0093;
        return 32'h5A00_3C3C ^ (32'(idx) * 32'h0001_0101);
    endfunction

    function automatic logic [31:0] randAddr();
        return {25'd0, 5'($urandom_range(0, 31)), 2'b00};
    endfunction

    // fixed-latency memory: a read strobed in cycle c shows up in cycle c+RD,
    // every other cycle delivers a poison word
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 128; k++) dev_mem[k] <= initWord(k);
            mem_loaded <= 1'b1;
        end else if (m_en && m_we) begin
            dev_mem[widx(m_addr)] <= m_wdata;
        end
        rd_pipe[0] <= (m_en && !m_we) ? dev_mem[widx(m_addr)] : 32'hBAD0_BAD0;
        for (int k = 1; k < RD; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign m_rdata = rd_pipe[RD-1];

    always @(posedge clk) begin
        m_rdata_b <= (m_en_b && !m_we_b) ? initWord(widx(m_addr_b)) : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic resetModel();
        free_at     = cyc;
        gnt_cyc     = -100;
        resp_cyc    = -100;
        last_d      = 1'b1;
        cur_d       = 1'b0;
        cur_we      = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        seen_ig     = 1'b0;
        seen_dg     = 1'b0;
    endtask

    // one clock cycle: predict from transaction timestamps, compare at the
    // falling edge, then advance past the next rising edge
    task automatic checkOutput();
        logic idle, e_ig, e_dg, e_men, e_irv, e_drv;
        @(negedge clk);
        idle = (cyc >= free_at);
        e_ig = 1'b0;
        e_dg = 1'b0;
        if (idle && rst_n) begin
            if (i_req && d_req) begin
                e_ig = last_d;
                e_dg = !last_d;
            end else begin
                e_ig = i_req;
                e_dg = d_req;
            end
        end
        e_men = (cyc == gnt_cyc + 1);
        e_irv = (cyc == resp_cyc) && !cur_d;
        e_drv = (cyc == resp_cyc) && cur_d;
        if (cyc == resp_cyc && !cur_we) begin
            if (cur_d) exp_d_rdata = resp_word;
            else       exp_i_rdata = resp_word;
        end
        chk("i_gnt", 32'(i_gnt), 32'(e_ig));
        chk("d_gnt", 32'(d_gnt), 32'(e_dg));
        chk("m_en", 32'(m_en), 32'(e_men));
        chk("busy", 32'(busy), 32'(!idle));
        chk("i_rvalid", 32'(i_rvalid), 32'(e_irv));
        chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
        chk("i_rdata", i_rdata, exp_i_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (e_men) begin
            chk("m_we", 32'(m_we), 32'(cur_we));
            chk("m_addr", m_addr, cur_addr);
            if (cur_we) chk("m_wdata", m_wdata, cur_wdata);
        end
        seen_ig = e_ig;
        seen_dg = e_dg;
        if (e_ig || e_dg) begin
            cur_d     = e_dg;
            cur_we    = e_dg && d_we;
            cur_addr  = e_dg ? d_addr : i_addr;
            cur_wdata = d_wdata;
            gnt_cyc   = cyc;
            resp_cyc  = cyc + (cur_we ? 2 : RD + 2);
            free_at   = resp_cyc + 1;
            last_d    = e_dg;
            if (cur_we) exp_mem[widx(cur_addr)] = cur_wdata;
            else        resp_word = exp_mem[widx(cur_addr)];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dwd);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i_req_b = 0; i_addr_b = 0; d_req_b = 0; d_we_b = 0; d_addr_b = 0; d_wdata_b = 0;
        cyc = 0;
        resetModel();
        for (int k = 0; k < 128; k++) exp_mem[k] = initWord(k);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        chk("rst_m_en", 32'(m_en), 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", {30'd0, i_gnt, d_gnt}, 0);
        chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_b_outs", {25'd0, i_gnt_b, i_rvalid_b, d_gnt_b, d_rvalid_b, m_en_b, m_we_b, busy_b}, 0);
        chk("rst_b_data", i_rdata_b | d_rdata_b | m_addr_b | m_wdata_b, 0);
        rst_n = 1'b1;

        $display("[TB] lone fetch");
        applyStimulus(1, 32'h100, 0, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] store");
        applyStimulus(0, 0, 1, 1, 32'h2000, 32'hDEAD_BEEF);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] late data request during fetch");
        applyStimulus(1, 32'h2000, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 1, 0, 32'h100, 0);
            if (seen_dg) break;
        end
        repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] withdrawn fetch while busy");
        applyStimulus(0, 0, 1, 1, 32'h8, 32'h1234_5678);
        applyStimulus(1, 32'h10, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] reset during read wait");
        applyStimulus(1, 32'h4, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_m_en", 32'(m_en), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_gnt", {30'd0, i_gnt, d_gnt}, 0);
        chk("abort_rvalid", {30'd0, i_rvalid, d_rvalid}, 0);
        chk("abort_m_addr", m_addr, 0);
        chk("abort_i_rdata", i_rdata, 0);
        chk("abort_d_rdata", d_rdata, 0);
        resetModel();
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] contention after reset");
        i_addr = 32'h20;
        d_addr = 32'h40;
        for (int k = 0; k < 36; k++) begin
            applyStimulus(1, i_addr, 1, 0, d_addr, 0);
            if (seen_ig) i_addr = randAddr();
            if (seen_dg) d_addr = randAddr();
        end
        repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 500; n++) begin
            if (i_req) begin
                if (seen_ig) begin
                    i_req  = ($urandom_range(0, 1) == 1);
                    i_addr = randAddr();
                end else if ($urandom_range(0, 15) == 0) begin
                    i_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = randAddr();
            end
            if (d_req) begin
                if (seen_dg) begin
                    d_req   = ($urandom_range(0, 1) == 1);
                    d_we    = ($urandom_range(0, 1) == 1);
                    d_addr  = randAddr();
                    d_wdata = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    d_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = ($urandom_range(0, 1) == 1);
                d_addr  = randAddr();
                d_wdata = $urandom;
            end
            checkOutput();
        end
        repeat (8) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] RD_LATENCY=1 read");
        for (int k = 0; k < 6; k++) begin
            i_req_b  = (k == 0);
            i_addr_b = 32'h0;
            @(negedge clk);
            chk("lat1_i_gnt", 32'(i_gnt_b), 32'(k == 0));
            chk("lat1_m_en", 32'(m_en_b), 32'(k == 1));
            chk("lat1_busy", 32'(busy_b), 32'(k >= 1 && k <= 3));
            chk("lat1_i_rvalid", 32'(i_rvalid_b), 32'(k == 3));
            chk("lat1_d_side", {30'd0, d_gnt_b, d_rvalid_b}, 0);
            if (k == 1) chk("lat1_m_addr", m_addr_b, 32'h0);
            if (k >= 3) chk("lat1_i_rdata", i_rdata_b, initWord(0));
            chk("lat1_d_rdata", d_rdata_b, 0);
            @(posedge clk);
            #1;
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
